// File: rtl/rand_draw_arbiter.sv
// Round-robin arbiter that shares one free-running random source among NREQ
// requesters, filters out-of-range and repeated samples, and returns one draw per request.
module rand_draw_arbiter #(
   parameter int NREQ      = 4,
   parameter int WIDTH     = 3,
   parameter int RANGE     = 7,
   parameter int NO_REPEAT = 1,
   parameter int RETRY_MAX = 7
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] rand_in_i,
   input  logic [NREQ-1:0]  req_i,
   output logic [NREQ-1:0]  ack_o,
   output logic [WIDTH-1:0] draw_val_o,
   output logic             busy_o,
   output logic             fallback_o,
   output logic [15:0]      draw_count_o
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [WIDTH:0]   RANGE_W    = (WIDTH+1)'(RANGE);
   localparam logic [WIDTH-1:0] LAST_MAX   = WIDTH'(RANGE - 1);
   localparam logic [3:0]       RETRY_LAST = 4'(RETRY_MAX - 1);
   localparam logic [IW-1:0]    RR_INIT    = IW'(NREQ - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      ACK  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [IW-1:0]    rr_q, rr_d;
   logic [3:0]       retry_q, retry_d;
   logic [WIDTH-1:0] last_q, last_d;
   logic             last_vld_q, last_vld_d;
   logic [NREQ-1:0]  mask_q, mask_d;
   logic [WIDTH-1:0] draw_val_q, draw_val_d;
   logic             fallback_q, fallback_d;
   logic [15:0]      cnt_q, cnt_d;

   logic [NREQ-1:0]  elig_s;
   logic [NREQ-1:0]  ack_vec_s;
   logic             found_s;
   logic [IW-1:0]    pick_s;
   logic             accept_s;
   logic [WIDTH-1:0] fb_val_s;

   // Round-robin search starting just above the last granted index.
   always_comb begin : pick_c
      int j;
      elig_s  = req_i & ~mask_q;
      found_s = 1'b0;
      pick_s  = rr_q;
      for (int k = 1; k <= NREQ; k++) begin
         j = ((int'(rr_q) + k) >= NREQ) ? (int'(rr_q) + k - NREQ) : (int'(rr_q) + k);
         if (!found_s && elig_s[j]) begin
            found_s = 1'b1;
            pick_s  = IW'(j);
         end else begin
            found_s = found_s;
         end
      end
   end

   // Sample qualification and the fallback value used once retries run out.
   always_comb begin
      accept_s  = ({1'b0, rand_in_i} < RANGE_W) &&
                  !((NO_REPEAT != 0) && last_vld_q && (rand_in_i == last_q));
      fb_val_s  = !last_vld_q          ? {WIDTH{1'b0}} :
                  (last_q == LAST_MAX) ? {WIDTH{1'b0}} :
                                         last_q + WIDTH'(1);
      ack_vec_s = (state_q == ACK) ? ({{(NREQ-1){1'b0}}, 1'b1} << idx_q) : {NREQ{1'b0}};
   end

   // Next-state logic; a low request always clears its mask bit, even on the ack cycle.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      rr_d       = rr_q;
      retry_d    = retry_q;
      last_d     = last_q;
      last_vld_d = last_vld_q;
      draw_val_d = draw_val_q;
      fallback_d = fallback_q;
      cnt_d      = cnt_q;
      mask_d     = (mask_q | ack_vec_s) & req_i;
      case (state_q)
         IDLE: begin
            if (found_s) begin
               state_d = DRAW;
               idx_d   = pick_s;
               rr_d    = pick_s;
               retry_d = 4'd0;
            end else begin
               state_d = IDLE;
            end
         end
         DRAW: begin
            if (!req_i[idx_q]) begin
               state_d = IDLE;
            end else if (accept_s) begin
               draw_val_d = rand_in_i;
               fallback_d = 1'b0;
               state_d    = ACK;
            end else if (retry_q == RETRY_LAST) begin
               draw_val_d = fb_val_s;
               fallback_d = 1'b1;
               state_d    = ACK;
            end else begin
               retry_d = retry_q + 4'd1;
            end
         end
         ACK: begin
            last_d     = draw_val_q;
            last_vld_d = 1'b1;
            cnt_d      = cnt_q + 16'd1;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         idx_q      <= {IW{1'b0}};
         rr_q       <= RR_INIT;
         retry_q    <= 4'd0;
         last_q     <= {WIDTH{1'b0}};
         last_vld_q <= 1'b0;
         mask_q     <= {NREQ{1'b0}};
         draw_val_q <= {WIDTH{1'b0}};
         fallback_q <= 1'b0;
         cnt_q      <= 16'd0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         rr_q       <= rr_d;
         retry_q    <= retry_d;
         last_q     <= last_d;
         last_vld_q <= last_vld_d;
         mask_q     <= mask_d;
         draw_val_q <= draw_val_d;
         fallback_q <= fallback_d;
         cnt_q      <= cnt_d;
      end
   end

   assign ack_o        = ack_vec_s;
   assign draw_val_o   = draw_val_q;
   assign busy_o       = (state_q != IDLE);
   assign fallback_o   = fallback_q && (state_q == ACK);
   assign draw_count_o = cnt_q;

endmodule

// File: tb/tb_rand_draw_arbiter.sv
// Bench for rand_draw_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model of the arbiter.
module tb_rand_draw_arbiter;

   localparam int NREQ      = 4;
   localparam int RANGE     = 7;
   localparam int RETRY_MAX = 7;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  rand_in;
   logic [3:0]  req;
   logic [3:0]  ack;
   logic [2:0]  draw_val;
   logic        busy;
   logic        fallback;
   logic [15:0] draw_count;

   int n_checks = 0;
   int n_err    = 0;

   // model: phase 0=waiting, 1=drawing, 2=acknowledging
   int       m_phase, m_idx, m_rr, m_tries, m_last, m_dv, m_cnt;
   bit       m_lvld, m_fb;
   bit [3:0] m_mask;

   rand_draw_arbiter #(.NREQ(NREQ), .WIDTH(3), .RANGE(RANGE), .NO_REPEAT(1), .RETRY_MAX(RETRY_MAX)) dut (
      .clk_i(clk), .rst_i(rst), .rand_in_i(rand_in), .req_i(req),
      .ack_o(ack), .draw_val_o(draw_val), .busy_o(busy),
      .fallback_o(fallback), .draw_count_o(draw_count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_idx = 0; m_rr = NREQ - 1; m_tries = 0;
      m_last = 0; m_dv = 0; m_cnt = 0; m_lvld = 0; m_fb = 0; m_mask = 4'b0000;
   endtask

   task automatic model_update(input int r, input logic [3:0] q);
      logic [3:0] ackv, elig;
      bit got;
      int j;
      ackv   = (m_phase == 2) ? (4'b0001 << m_idx) : 4'b0000;
      elig   = q & ~m_mask;
      m_mask = (m_mask | ackv) & q;
      case (m_phase)
         0: begin
            got = 0;
            for (int k = 1; k <= NREQ; k++) begin
               j = (m_rr + k) % NREQ;
               if (!got && elig[j]) begin
                  got = 1; m_idx = j; m_rr = j; m_tries = 0; m_phase = 1;
               end
            end
         end
         1: begin
            if (!q[m_idx]) m_phase = 0;
            else if (r < RANGE && !(m_lvld && r == m_last)) begin
               m_dv = r; m_fb = 0; m_phase = 2;
            end else if (m_tries + 1 == RETRY_MAX) begin
               m_dv = m_lvld ? (m_last + 1) % RANGE : 0; m_fb = 1; m_phase = 2;
            end else m_tries++;
         end
         2: begin
            m_last = m_dv; m_lvld = 1; m_cnt = (m_cnt + 1) % 65536; m_phase = 0;
         end
         default: m_phase = 0;
      endcase
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".ack"}, ack, (m_phase == 2) ? (32'd1 << m_idx) : 32'd0);
      chk({tag, ".draw_val"}, draw_val, m_dv);
      chk({tag, ".busy"}, busy, (m_phase != 0) ? 32'd1 : 32'd0);
      chk({tag, ".fallback"}, fallback, (m_phase == 2 && m_fb) ? 32'd1 : 32'd0);
      chk({tag, ".draw_count"}, draw_count, m_cnt);
   endtask

   task automatic step(input logic [2:0] r, input logic [3:0] q);
      rand_in = r;
      req     = q;
      @(posedge clk);
      #1;
      model_update(int'(r), q);
      check_outputs("cyc");
   endtask

   task automatic do_reset();
      rst = 1'b1; req = 4'b0000; rand_in = 3'd0;
      @(posedge clk);
      #1;
      model_reset();
      check_outputs("reset");
      rst = 1'b0;
   endtask

   initial begin : main
      logic [3:0] reqv;
      logic [2:0] rv;
      int order[5];
      int ng, low_idx, got;

      rst = 1'b1; req = 4'b0000; rand_in = 3'd0;
      #3;
      do_reset();

      // single requester, value 5
      step(3'd5, 4'b0001);
      chk("single.busy0", busy, 1'b1);
      chk("single.noack", ack, 4'b0000);
      step(3'd5, 4'b0001);
      chk("single.ack", ack, 4'b0001);
      chk("single.val", draw_val, 3'd5);
      step(3'd5, 4'b0000);
      chk("single.idle", busy, 1'b0);
      chk("single.count", draw_count, 16'd1);

      // round-robin with each requester dropping for one cycle after its ack
      do_reset();
      for (int k = 0; k < 5; k++) order[k] = -1;
      reqv = 4'b1111; ng = 0; low_idx = -1;
      for (int c = 0; c < 60 && ng < 5; c++) begin
         step(3'(ng), reqv);
         if (low_idx >= 0) begin
            reqv[low_idx] = 1'b1;
            low_idx = -1;
         end
         if (ack != 4'b0000) begin
            got = 0;
            for (int i = 0; i < NREQ; i++) if (ack[i]) got = i;
            order[ng] = got;
            ng++;
            reqv[got] = 1'b0;
            low_idx = got;
         end
      end
      chk("rr.grants", ng, 5);
      chk("rr.order0", order[0], 0);
      chk("rr.order1", order[1], 1);
      chk("rr.order2", order[2], 2);
      chk("rr.order3", order[3], 3);
      chk("rr.order4", order[4], 0);
      step(3'd0, 4'b0000);
      step(3'd0, 4'b0000);
      chk("rr.count", draw_count, 16'd5);

      // out-of-range samples rejected, then 2 accepted
      step(3'd7, 4'b0001);
      for (int k = 0; k < 3; k++) begin
         step(3'd7, 4'b0001);
         chk("rej.wait", ack, 4'b0000);
      end
      step(3'd2, 4'b0001);
      chk("rej.ack", ack, 4'b0001);
      chk("rej.val", draw_val, 3'd2);
      chk("rej.fb", fallback, 1'b0);
      step(3'd2, 4'b0000);

      // last issued 6, source stuck at 6: fallback wraps to 0
      step(3'd6, 4'b0001);
      step(3'd6, 4'b0001);
      chk("rep.setup", draw_val, 3'd6);
      step(3'd6, 4'b0000);
      step(3'd6, 4'b0010);
      for (int k = 0; k < RETRY_MAX - 1; k++) begin
         step(3'd6, 4'b0010);
         chk("rep.wait", ack, 4'b0000);
      end
      step(3'd6, 4'b0010);
      chk("rep.ack", ack, 4'b0010);
      chk("rep.val", draw_val, 3'd0);
      chk("rep.fb", fallback, 1'b1);
      step(3'd6, 4'b0000);

      // stuck out of range with no history: fallback 0
      do_reset();
      step(3'd7, 4'b0001);
      for (int k = 0; k < RETRY_MAX - 1; k++) step(3'd7, 4'b0001);
      step(3'd7, 4'b0001);
      chk("oor.ack", ack, 4'b0001);
      chk("oor.val", draw_val, 3'd0);
      chk("oor.fb", fallback, 1'b1);
      step(3'd7, 4'b0000);

      // abort in DRAW
      step(3'd1, 4'b0100);
      step(3'd1, 4'b0000);
      chk("abort.noack", ack, 4'b0000);
      chk("abort.idle", busy, 1'b0);
      step(3'd1, 4'b0000);
      chk("abort.count", draw_count, 16'd1);

      // mask: held request is not re-granted until seen low
      step(3'd3, 4'b0010);
      step(3'd3, 4'b0010);
      chk("mask.ack1", ack, 4'b0010);
      for (int k = 0; k < 5; k++) begin
         step(3'd4, 4'b0010);
         chk("mask.hold", ack, 4'b0000);
      end
      step(3'd4, 4'b0000);
      step(3'd4, 4'b0010);
      step(3'd4, 4'b0010);
      chk("mask.ack2", ack, 4'b0010);
      step(3'd4, 4'b0000);

      // async reset in DRAW
      step(3'd5, 4'b0100);
      chk("arst.busy_before", busy, 1'b1);
      #1 rst = 1'b1;
      #1;
      chk("arst.ack", ack, 4'b0000);
      chk("arst.val", draw_val, 3'd0);
      chk("arst.busy", busy, 1'b0);
      chk("arst.fb", fallback, 1'b0);
      chk("arst.count", draw_count, 16'd0);
      model_reset();
      #1 rst = 1'b0;
      step(3'd2, 4'b1111);
      step(3'd2, 4'b1111);
      chk("arst.first", ack, 4'b0001);
      step(3'd2, 4'b0000);

      // random traffic
      reqv = 4'b0000; rv = 3'd0;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 3) == 0) reqv = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 0) rv = 3'($urandom_range(0, 7));
         step(rv, reqv);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/rand_draw_arbiter.md
Name: rand_draw_arbiter

Overview:
- Shares one free-running random source (3-bit value, 0..6, changes every clock) among several game/terminal requesters.
- Arbitrates round-robin and samples the source on behalf of the granted requester.
- Rejects out-of-range values and, optionally, back-to-back repeats.
- Returns the draw with a single-cycle ack; sits between the random source and the consumer FSMs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 3, width of rand_in and draw_val.
- RANGE, 7, legal values are 0..RANGE-1 (RANGE <= 2**WIDTH).
- NO_REPEAT, 1, when 1, a draw equal to the previously issued value is rejected.
- RETRY_MAX, 7, maximum rejected samples before fallback (1..15).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- rand_in  input  WIDTH  random source value, sampled only in DRAW.
- req  input  NREQ  level request per requester; held until ack.
- ack  output  NREQ  one-hot, single-cycle; draw_val is valid while asserted.
- draw_val  output  WIDTH  issued value; holds its last value between acks.
- busy  output  1  high in DRAW and ACK.
- fallback  output  1  high with ack when the value came from fallback.
- draw_count  output  16  count of completed draws; wraps 65535 -> 0.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values:
  - Outputs: ack=0, draw_val=0, busy=0, fallback=0, draw_count=0.
  - Internal: state=IDLE, rr_ptr=NREQ-1, last_vld=0, last_val=0, retry=0, mask=0.
- Eligibility: elig = req & ~mask. mask[i] sets on ack[i] and clears on any cycle req[i]=0. A requester therefore receives one draw per req assertion (4-phase).
- IDLE:
  - If elig != 0, pick the first set bit searching from rr_ptr+1 upward with wrap.
  - Latch it as idx, set rr_ptr=idx, retry=0, go to DRAW. Otherwise stay.
- DRAW, each cycle sample rand_in, with these rules in priority order:
  - req[idx]=0: abort to IDLE. No ack; last_val and draw_count unchanged.
  - Sample accepted: rand_in < RANGE and not (NO_REPEAT and last_vld and rand_in == last_val).
    - Latch draw_val=rand_in, fallback=0, go to ACK.
  - Sample rejected with retry == RETRY_MAX-1: fallback value.
    - Value is (last_val+1) mod RANGE if last_vld, else 0.
    - Latch draw_val to it, fallback=1, go to ACK.
  - Otherwise retry++ and stay in DRAW.
- ACK (exactly one cycle):
  - ack[idx]=1, fallback as latched.
  - last_val=draw_val, last_vld=1, draw_count++ (wrap), mask[idx]=1.
  - Return to IDLE. The next grant can start in the following cycle (IDLE decides on that edge).
- Latency: req high before edge E0 with state IDLE and a first sample accepted gives DRAW during E0..E1 and ACK during E1..E2. ack is visible 2 edges after the request is seen. Worst case is RETRY_MAX+1 edges.
- Handshake:
  - Requester must not drop req before ack unless abandoning the draw (abort rule).
  - After ack, no re-grant to that requester until req has been seen low at least 1 cycle.
- Simultaneous events:
  - req[i] dropping in the same cycle mask[i] would set: mask clear wins, so mask ends 0.
  - New requests arriving during DRAW/ACK wait; there is no preemption.
- Reset mid-operation returns to IDLE immediately. No ack is emitted and any pending draw is lost.
- Arithmetic: the fallback mod is computed as wrap-to-0 when last_val+1 == RANGE; no divider is needed. retry width is 4 bits.

Test Plan:
- Reset then single requester: rand_in=5, req=0001 -> ack=0001 two edges later, draw_val=5, draw_count=1, busy high for 2 cycles.
- Round-robin: req=1111 held, each requester toggling req low for 1 cycle after its ack -> grant order 0,1,2,3,0 and draw_count=5.
- Rejection: rand_in=7 (out of range) for 3 cycles then 2 -> ack after 3 extra cycles, draw_val=2, fallback=0.
- NO_REPEAT fallback:
  - Setup: last issued 6, then rand_in stuck at 6.
  - Response: after RETRY_MAX=7 samples, draw_val=0 (wrap) and fallback=1.
  - Also: rand_in stuck at 7 with last_vld=0 -> draw_val=0, fallback=1.
- Abort and mask: requester 2 drops req in DRAW -> no ack, draw_count unchanged. Requester 1 holding req after ack -> no second ack until req low 1 cycle.
- Async reset asserted in DRAW between clock edges -> all outputs 0 immediately. Next req to requester 0 is granted first (rr_ptr=NREQ-1).
